activation_pipe: RTL and testbench

//  Parametrised, multi-mode activation unit between the systolic-array output and the

---
 rtl/activation_pipe.sv | 194 +++++++++++++++++++
 tb/tb_activation_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : activation_pipe
//  Purpose  : Multi-mode activation unit that sits between the systolic-array
//             output and the output buffer / pooling stage. Each DWIDTH lane
//             of a LANES-wide vector can be bypassed, or passed through ReLU,
//             leaky ReLU or clamped ReLU. Lanes can be zeroed individually
//             with a validity mask. The unit has a 2-stage pipeline, counts a
//             programmed number of vectors per run, and raises a done level
//             once every vector of the run has been output.
//  Ports    :
//    clk                 in   rising-edge clock
//    reset               in   asynchronous reset, active low
//    enable_activation   in   0 = whole block is a combinational pass-through
//    start               in   1-cycle pulse: latch config and begin a run
//    mode                in   00 bypass, 01 ReLU, 10 leaky ReLU, 11 clamp
//    leak_shift          in   leaky ReLU: negative x becomes x >>> leak_shift
//    clamp_val           in   clamp ReLU: upper bound (unsigned)
//    num_vectors         in   number of vectors in a run
//    in_data_available   in   inp_data is valid this cycle
//    inp_data            in   input vector, lane 1 in the least significant bits
//    validity_mask       in   bit i-1 = 0 forces lane i to zero
//    out_data            out  activated vector
//    out_data_available  out  out_data is valid this cycle
//    done_activation     out  run complete (level)
//  Revision : 1.0 - initial release
// ============================================================================
module activation_pipe #(
  parameter int DWIDTH    = 8,
  parameter int LANES     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable_activation,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [2:0]              leak_shift,
  input  logic [DWIDTH-1:0]       clamp_val,
  input  logic [CNT_WIDTH-1:0]    num_vectors,
  input  logic                    in_data_available,
  input  logic [LANES*DWIDTH-1:0] inp_data,
  input  logic [LANES-1:0]        validity_mask,
  output logic [LANES*DWIDTH-1:0] out_data,
  output logic                    out_data_available,
  output logic                    done_activation
);

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_RELU   = 2'b01;
  localparam logic [1:0] MODE_LEAKY  = 2'b10;
  localparam logic [1:0] MODE_CLAMP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic                   done_q;

  // Configuration latched at start so the run is immune to input changes.
  logic [1:0]             cfg_mode;
  logic [2:0]             cfg_shift;
  logic [DWIDTH-1:0]      cfg_clamp;
  logic [CNT_WIDTH-1:0]   cfg_num;

  logic [CNT_WIDTH-1:0]   in_cnt;
  logic [CNT_WIDTH-1:0]   out_cnt;
  logic [CNT_WIDTH-1:0]   out_cnt_next;

  logic                   s1_valid;
  logic [LANES*DWIDTH-1:0] s1_data;
  logic [LANES-1:0]       s1_mask;
  logic                   s2_valid;
  logic [LANES*DWIDTH-1:0] s2_data;

  logic [LANES*DWIDTH-1:0] act_vec;
  logic                   accept;

  // A start pulse never coincides with acceptance: acceptance needs RUN,
  // and the state only becomes RUN on the edge that samples start.
  assign accept       = in_data_available && (state == RUN) && (in_cnt < cfg_num);
  assign out_cnt_next = out_cnt + 1'b1;

  // --------------------------------------------------------------------------
  // Per-lane activation on stage-1 data
  // --------------------------------------------------------------------------
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [DWIDTH-1:0] x;
      logic        [DWIDTH-1:0] act;

      assign x = s1_data[l*DWIDTH +: DWIDTH];

      always_comb begin
        act = x;
        if (!s1_mask[l]) begin
          act = '0;
        end else begin
          case (cfg_mode)
            MODE_BYPASS: act = x;
            MODE_RELU:   act = x[DWIDTH-1] ? '0 : x;
            // Arithmetic shift keeps the sign, so it rounds toward -inf.
            MODE_LEAKY:  act = x[DWIDTH-1] ? (x >>> cfg_shift) : x;
            // x is non-negative in the compare branch, so an unsigned
            // compare against the unsigned bound is exact.
            MODE_CLAMP:  act = x[DWIDTH-1] ? '0 :
                               (($unsigned(x) > cfg_clamp) ? cfg_clamp : x);
            default:     act = x;
          endcase
        end
      end

      assign act_vec[l*DWIDTH +: DWIDTH] = act;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM, counters and pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      cfg_mode  <= '0;
      cfg_shift <= '0;
      cfg_clamp <= '0;
      cfg_num   <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_mask   <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= inp_data;
        s1_mask <= validity_mask;
        in_cnt  <= in_cnt + 1'b1;
      end

      // Output register holds zero whenever no vector is presented.
      s2_valid <= s1_valid;
      s2_data  <= s1_valid ? act_vec : '0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            cfg_mode  <= mode;
            cfg_shift <= leak_shift;
            cfg_clamp <= clamp_val;
            cfg_num   <= num_vectors;
            in_cnt    <= '0;
            out_cnt   <= '0;
            if (num_vectors == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              done_q <= 1'b0;
            end
          end
        end
        RUN: begin
          if (s2_valid) begin
            out_cnt <= out_cnt_next;
            if (out_cnt_next == cfg_num) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: with the block disabled everything is a wire-through.
  // --------------------------------------------------------------------------
  assign out_data           = enable_activation ? s2_data  : inp_data;
  assign out_data_available = enable_activation ? s2_valid : in_data_available;
  assign done_activation    = enable_activation ? done_q   : 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_activation_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_activation_pipe
//  Purpose  : Directed scoreboard bench for activation_pipe. Stimulus pushes
//             the expected vector and its expected output cycle into a queue;
//             a monitor on the falling edge pops and compares every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_activation_pipe;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int CW = 8;

  localparam logic [1:0] M_BYP   = 2'b00;
  localparam logic [1:0] M_RELU  = 2'b01;
  localparam logic [1:0] M_LEAKY = 2'b10;
  localparam logic [1:0] M_CLAMP = 2'b11;

  logic              clk;
  logic              reset;
  logic              enable_activation;
  logic              start;
  logic [1:0]        mode;
  logic [2:0]        leak_shift;
  logic [DW-1:0]     clamp_val;
  logic [CW-1:0]     num_vectors;
  logic              in_data_available;
  logic [LN*DW-1:0]  inp_data;
  logic [LN-1:0]     validity_mask;
  logic [LN*DW-1:0]  out_data;
  logic              out_data_available;
  logic              done_activation;

  activation_pipe #(.DWIDTH(DW), .LANES(LN), .CNT_WIDTH(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable_activation  (enable_activation),
    .start              (start),
    .mode               (mode),
    .leak_shift         (leak_shift),
    .clamp_val          (clamp_val),
    .num_vectors        (num_vectors),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_activation    (done_activation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Lane 1 occupies the least significant byte.
  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    logic [31:0] r;
    r = {d[7:0], c[7:0], b[7:0], a[7:0]};
    return r;
  endfunction

  // Monitor: every presented output must match the head of the scoreboard
  // and arrive exactly on its expected cycle; an overdue entry is a miss.
  always @(negedge clk) begin
    if (reset && enable_activation) begin
      if (out_data_available) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", out_data, 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_cycle", cyc, e.cyc);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("missing_output", 32'd0, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [2:0] ls,
                           input logic [7:0] cv, input logic [7:0] nv);
    start       = 1'b1;
    mode        = m;
    leak_shift  = ls;
    clamp_val   = cv;
    num_vectors = nv;
    tick();
    start       = 1'b0;
    // Scramble config to prove it was latched.
    mode        = ~m;
    leak_shift  = ~ls;
    clamp_val   = ~cv;
    num_vectors = 8'd200;
  endtask

  task automatic send(input logic [31:0] v, input logic [3:0] m,
                      input bit expect_out, input logic [31:0] ev);
    exp_t e;
    in_data_available = 1'b1;
    inp_data          = v;
    validity_mask     = m;
    if (expect_out) begin
      e.data = ev;
      e.cyc  = cyc + 2;
      sb.push_back(e);
    end
    tick();
    in_data_available = 1'b0;
    inp_data          = 32'hA5A5_A5A5;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      if (done_activation) break;
      tick();
    end
    chk("done_wait", {31'd0, done_activation}, 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    int          last;

    reset             = 1'b0;
    enable_activation = 1'b1;
    start             = 1'b0;
    mode              = '0;
    leak_shift        = '0;
    clamp_val         = '0;
    num_vectors       = '0;
    in_data_available = 1'b0;
    inp_data          = '0;
    validity_mask     = '1;
    tick();
    tick();
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_avail", {31'd0, out_data_available}, 32'd0);
    chk("rst_done", {31'd0, done_activation}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: ReLU, 3 back-to-back vectors, done the cycle after the last output
    start_run(M_RELU, 3'd0, 8'd0, 8'd3);
    chk("run_done_low", {31'd0, done_activation}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      last = cyc;
      send(pk(-5, 7, -128, 127), 4'b1111, 1'b1, pk(0, 7, 0, 127));
    end
    tick();
    chk("done_at_last_out", {31'd0, done_activation}, 32'd0);
    tick();
    chk("done_after_last", {31'd0, done_activation}, 32'd1);
    chk("done_cycle", cyc, last + 3);

    // 2: leaky, then clamp (start from DONE restarts and drops done)
    start_run(M_LEAKY, 3'd2, 8'd0, 8'd2);
    chk("done_falls", {31'd0, done_activation}, 32'd0);
    send(pk(-8, -1, -128, 20), 4'b1111, 1'b1, pk(-2, -1, -32, 20));
    send(pk(-9, 5, -1, 0), 4'b1111, 1'b1, pk(-3, 5, -1, 0));
    wait_done(10);
    start_run(M_CLAMP, 3'd0, 8'd6, 8'd1);
    send(pk(-3, 4, 6, 100), 4'b1111, 1'b1, pk(0, 4, 6, 6));
    wait_done(10);

    // 3: masking, then extra inputs beyond num_vectors are dropped
    start_run(M_BYP, 3'd0, 8'd0, 8'd1);
    send(pk(1, 2, 3, 4), 4'b0101, 1'b1, pk(1, 0, 3, 0));
    wait_done(10);
    start_run(M_BYP, 3'd0, 8'd0, 8'd2);
    for (int i = 0; i < 5; i++)
      send(pk(10 + i, -20, 30, -40), 4'b1111, (i < 2), pk(10 + i, -20, 30, -40));
    wait_done(10);
    for (int i = 0; i < 4; i++) tick();

    // 4: num_vectors = 0, then start ignored while running
    start_run(M_RELU, 3'd0, 8'd0, 8'd0);
    chk("zero_run_done", {31'd0, done_activation}, 32'd1);
    send(pk(1, 1, 1, 1), 4'b1111, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    start_run(M_RELU, 3'd0, 8'd0, 8'd2);
    send(pk(-1, 2, -3, 4), 4'b1111, 1'b1, pk(0, 2, 0, 4));
    start       = 1'b1;
    mode        = M_BYP;
    num_vectors = 8'd0;
    send(pk(-7, -7, 9, 9), 4'b1111, 1'b1, pk(0, 0, 9, 9));
    start       = 1'b0;
    wait_done(10);

    // 5: asynchronous reset with two vectors in flight
    start_run(M_RELU, 3'd0, 8'd0, 8'd4);
    send(pk(3, 3, 3, 3), 4'b1111, 1'b1, pk(3, 3, 3, 3));
    send(pk(4, 4, 4, 4), 4'b1111, 1'b0, 32'd0);
    chk("pre_reset_avail", {31'd0, out_data_available}, 32'd1);
    #2;
    sb.delete();
    reset = 1'b0;
    #1;
    chk("async_rst_data", out_data, 32'd0);
    chk("async_rst_avail", {31'd0, out_data_available}, 32'd0);
    chk("async_rst_done", {31'd0, done_activation}, 32'd0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) send(pk(5, 5, 5, 5), 4'b1111, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_done", {31'd0, done_activation}, 32'd0);

    // 6: disabled block is a combinational pass-through
    enable_activation = 1'b0;
    in_data_available = 1'b1;
    v                 = pk(-5, 17, -100, 42);
    inp_data          = v;
    #1;
    chk("bypass_data", out_data, v);
    chk("bypass_avail", {31'd0, out_data_available}, 32'd1);
    chk("bypass_done", {31'd0, done_activation}, 32'd1);
    in_data_available = 1'b0;
    inp_data          = 32'h1234_5678;
    #1;
    chk("bypass_data2", out_data, 32'h1234_5678);
    chk("bypass_avail2", {31'd0, out_data_available}, 32'd0);
    tick();
    enable_activation = 1'b1;
    tick();

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
